// File: rtl/awb_pkg.sv
// awb_pkg: shared constants and types for the auto-white-balance stage.
//   GAIN_*          : gain format (unsigned Q2.8, 1.0 = 256)
//   CH_W / *_LSB    : RGB field slicing of the 24-bit pixel bus
//   awb_state_e     : gain-computation sequencer states
package awb_pkg;

  localparam int GAIN_W    = 10;
  localparam int GAIN_FRAC = 8;
  localparam int GAIN_ONE  = 256;
  localparam int GAIN_MAX  = 1023;

  localparam int CH_W  = 8;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    DIV_R,
    DIV_B,
    UPDATE
  } awb_state_e;

endpackage

// File: rtl/awb_div.sv
// awb_div: sequential restoring divider producing a saturated gain.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor and begin (overrides abort/busy)
//   abort     : drop the division in progress
//   dividend  : DVD_W-bit numerator
//   divisor   : DVS_W-bit denominator; zero yields Q_ONE
//   done      : one-cycle pulse when quotient is valid
//   quotient  : Q_W-bit result, saturated to 2^Q_W-1, held until next done
module awb_div #(
  parameter int DVD_W = 40,
  parameter int DVS_W = 32,
  parameter int Q_W   = 10,
  parameter int Q_ONE = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam int Q_MAX = (1 << Q_W) - 1;

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [DVD_W-1:0] dvd;
  logic [DVD_W-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  logic [DVS_W-1:0] step_rem;
  logic [DVS_W-1:0] step_dvs;
  logic             step_bit;
  logic [DVD_W-1:0] step_quo;
  logic [DVS_W:0]   trial;
  logic             ge;
  logic [DVS_W:0]   rem_nxt;
  logic [DVD_W-1:0] quo_nxt;
  logic [Q_W-1:0]   quo_sat;

  // The first quotient bit is resolved on the start edge itself, straight
  // from the input operands, so a run takes DVD_W edges including the load.
  always_comb begin
    step_rem = start ? '0 : rem;
    step_dvs = start ? divisor : dvs;
    step_bit = start ? dividend[DVD_W-1] : dvd[DVD_W-1];
    step_quo = start ? '0 : quo;
    trial    = {step_rem, step_bit};
    ge       = (trial >= {1'b0, step_dvs});
    rem_nxt  = ge ? (trial - {1'b0, step_dvs}) : trial;
    quo_nxt  = {step_quo[DVD_W-2:0], ge};
    quo_sat  = (quo_nxt > DVD_W'(Q_MAX)) ? Q_W'(Q_MAX) : quo_nxt[Q_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      dvs      <= '0;
      dvd      <= '0;
      quo      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        if (divisor == '0) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= Q_W'(Q_ONE);
        end else begin
          rem  <= rem_nxt[DVS_W-1:0];
          quo  <= quo_nxt;
          dvd  <= dividend << 1;
          dvs  <= divisor;
          cnt  <= CNT_W'(DVD_W - 1);
          busy <= 1'b1;
        end
      end else if (abort) begin
        busy <= 1'b0;
      end else if (busy) begin
        rem <= rem_nxt[DVS_W-1:0];
        quo <= quo_nxt;
        dvd <= dvd << 1;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= quo_sat;
        end
      end
    end
  end

endmodule

// File: rtl/awb_gain_apply.sv
// awb_gain_apply: gray-world auto-white-balance.
//   Collects per-frame R/G/B sums, derives R and B gains relative to G during
//   blanking, and applies them to the next frame through a 3-stage pipeline.
//   I_clk, I_rst           : pixel clock, synchronous active-high reset
//   I_awb_en               : 1 = apply gains, 0 = unity gain (same latency)
//   I_vs, I_hs, I_de       : sync / data enable in; rising I_vs = new frame
//   I_rgb                  : pixel in, [23:16] R, [15:8] G, [7:0] B
//   O_vs, O_hs, O_de, O_rgb: same stream, 3 cycles later, gain-corrected
//   O_gain_r, O_gain_b     : gains currently applied (Q2.8)
module awb_gain_apply #(
  parameter int ACC_W     = 32,
  parameter int GAIN_W    = 10,
  parameter int GAIN_FRAC = 8
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_awb_en,
  input  logic              I_vs,
  input  logic              I_hs,
  input  logic              I_de,
  input  logic [23:0]       I_rgb,
  output logic              O_vs,
  output logic              O_hs,
  output logic              O_de,
  output logic [23:0]       O_rgb,
  output logic [GAIN_W-1:0] O_gain_r,
  output logic [GAIN_W-1:0] O_gain_b
);

  import awb_pkg::*;

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(GAIN_ONE);
  localparam int DVD_W  = ACC_W + GAIN_FRAC;
  localparam int P_W    = CH_W + GAIN_W;
  localparam int S2_W   = P_W - GAIN_FRAC;
  localparam int ROUND  = 1 << (GAIN_FRAC - 1);
  localparam int CH_MAX = (1 << CH_W) - 1;

  // ---------------- statistics and gain sequencing ----------------
  logic              vs_prev;
  logic              vs_rise;
  logic [ACC_W-1:0]  acc_r, acc_g, acc_b;
  logic [ACC_W-1:0]  snap_g, snap_b;
  logic [GAIN_W-1:0] shadow_r, shadow_b;
  logic [GAIN_W-1:0] active_r, active_b;
  logic [GAIN_W-1:0] res_r;
  awb_state_e        state, state_nxt;

  logic              div_start, div_abort, div_done;
  logic [DVD_W-1:0]  div_dividend;
  logic [ACC_W-1:0]  div_divisor;
  logic [GAIN_W-1:0] div_q;

  // The R division launches on the vs edge itself, fed directly from the
  // accumulators, so only G and B need a snapshot for the later B pass.
  always_comb begin
    vs_rise      = I_vs & ~vs_prev;
    state_nxt    = state;
    div_start    = vs_rise | ((state == DIV_R) & div_done);
    div_abort    = vs_rise & (state != IDLE);
    div_dividend = vs_rise ? {acc_g, {GAIN_FRAC{1'b0}}}
                           : {snap_g, {GAIN_FRAC{1'b0}}};
    div_divisor  = vs_rise ? acc_r : snap_b;
    if (vs_rise) begin
      state_nxt = DIV_R;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        DIV_R:   if (div_done) state_nxt = DIV_B;
        DIV_B:   if (div_done) state_nxt = UPDATE;
        UPDATE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      vs_prev  <= 1'b0;
      state    <= IDLE;
      acc_r    <= '0;
      acc_g    <= '0;
      acc_b    <= '0;
      snap_g   <= '0;
      snap_b   <= '0;
      shadow_r <= UNITY;
      shadow_b <= UNITY;
      active_r <= UNITY;
      active_b <= UNITY;
      res_r    <= UNITY;
    end else begin
      vs_prev <= I_vs;
      state   <= state_nxt;
      if (vs_rise) begin
        snap_g   <= acc_g;
        snap_b   <= acc_b;
        acc_r    <= '0;
        acc_g    <= '0;
        acc_b    <= '0;
        active_r <= shadow_r;
        active_b <= shadow_b;
      end else if (I_de) begin
        acc_r <= acc_r + ACC_W'(I_rgb[R_LSB +: CH_W]);
        acc_g <= acc_g + ACC_W'(I_rgb[G_LSB +: CH_W]);
        acc_b <= acc_b + ACC_W'(I_rgb[B_LSB +: CH_W]);
      end
      if ((state == DIV_R) && div_done && !vs_rise) begin
        res_r <= div_q;
      end
      // The divider keeps its last result, so the B gain is read from it here.
      if ((state == UPDATE) && !vs_rise) begin
        shadow_r <= res_r;
        shadow_b <= div_q;
      end
    end
  end

  awb_div #(
    .DVD_W (DVD_W),
    .DVS_W (ACC_W),
    .Q_W   (GAIN_W),
    .Q_ONE (GAIN_ONE)
  ) u_div (
    .clk      (I_clk),
    .rst      (I_rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_q)
  );

  assign O_gain_r = active_r;
  assign O_gain_b = active_b;

  // ---------------- apply pipeline ----------------
  logic [CH_W-1:0]   pix  [3];
  logic [GAIN_W-1:0] gsel [3];
  logic [P_W-1:0]    s1   [3];
  logic [S2_W-1:0]   s2   [3];
  logic [CH_W-1:0]   s3   [3];
  logic [2:0]        sync_d [3];

  always_comb begin
    pix[0]  = I_rgb[R_LSB +: CH_W];
    pix[1]  = I_rgb[G_LSB +: CH_W];
    pix[2]  = I_rgb[B_LSB +: CH_W];
    gsel[0] = I_awb_en ? active_r : UNITY;
    gsel[1] = UNITY;
    gsel[2] = I_awb_en ? active_b : UNITY;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int unsigned c = 0; c < 3; c++) begin
        s1[c]     <= '0;
        s2[c]     <= '0;
        s3[c]     <= '0;
        sync_d[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < 3; c++) begin
        s1[c] <= P_W'(pix[c]) * P_W'(gsel[c]);
        s2[c] <= S2_W'((s1[c] + P_W'(ROUND)) >> GAIN_FRAC);
        s3[c] <= (s2[c] > S2_W'(CH_MAX)) ? '1 : s2[c][CH_W-1:0];
      end
      sync_d[0] <= {I_vs, I_hs, I_de};
      sync_d[1] <= sync_d[0];
      sync_d[2] <= sync_d[1];
    end
  end

  assign O_rgb = {s3[0], s3[1], s3[2]};
  assign O_vs  = sync_d[2][2];
  assign O_hs  = sync_d[2][1];
  assign O_de  = sync_d[2][0];

endmodule

// File: tb/tb_awb_gain_apply.sv
// tb_awb_gain_apply: directed bench for awb_gain_apply with hand-computed
// expected pixels and gains. Inputs change on the falling edge; outputs are
// compared on the falling edge against the entry queued three cycles earlier.
module tb_awb_gain_apply;

  logic        clk = 1'b0;
  logic        rst, awb_en, vs, hs, de;
  logic [23:0] rgb;
  logic        o_vs, o_hs, o_de;
  logic [23:0] o_rgb;
  logic [9:0]  o_gain_r, o_gain_b;

  int checks = 0;
  int errors = 0;

  logic [26:0] hist [$];

  always #5 clk = ~clk;

  awb_gain_apply #(
    .ACC_W     (32),
    .GAIN_W    (10),
    .GAIN_FRAC (8)
  ) dut (
    .I_clk    (clk),
    .I_rst    (rst),
    .I_awb_en (awb_en),
    .I_vs     (vs),
    .I_hs     (hs),
    .I_de     (de),
    .I_rgb    (rgb),
    .O_vs     (o_vs),
    .O_hs     (o_hs),
    .O_de     (o_de),
    .O_rgb    (o_rgb),
    .O_gain_r (o_gain_r),
    .O_gain_b (o_gain_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; the output for the input driven two
  // calls earlier is then checked.
  task automatic drive(input logic v, input logic h, input logic d,
                       input logic [23:0] px, input logic [23:0] ex);
    logic [26:0] e;
    vs  = v;
    hs  = h;
    de  = d;
    rgb = px;
    hist.push_back({v, h, d, ex});
    @(negedge clk);
    if (hist.size() == 3) begin
      e = hist.pop_front();
      check("rgb", {8'h0, o_rgb}, {8'h0, e[23:0]});
      check("sync", {29'h0, o_vs, o_hs, o_de}, {29'h0, e[26:24]});
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
  endtask

  task automatic pixels(input int n, input logic [23:0] px, input logic [23:0] ex);
    for (int i = 0; i < n; i++) drive(1'b0, i[0], 1'b1, px, ex);
  endtask

  task automatic frame_edge(input string tag, input int gr, input int gb);
    drive(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    check({tag, "_gain_r"}, {22'h0, o_gain_r}, gr);
    check({tag, "_gain_b"}, {22'h0, o_gain_b}, gb);
  endtask

  initial begin
    logic [23:0] r;

    // Reset with random inputs
    rst    = 1'b1;
    vs     = 1'b0;
    awb_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rgb    = 24'($urandom);
      hs     = 1'($urandom);
      de     = 1'($urandom);
      awb_en = 1'($urandom);
      @(negedge clk);
      check("rst_rgb", {8'h0, o_rgb}, 32'h0);
      check("rst_sync", {29'h0, o_vs, o_hs, o_de}, 32'h0);
      check("rst_gain_r", {22'h0, o_gain_r}, 32'd256);
      check("rst_gain_b", {22'h0, o_gain_b}, 32'd256);
    end

    // Release: two cycles of cleared pipeline, then inputs tracked
    rst = 1'b0;
    hist.push_back(27'h0);
    hist.push_back(27'h0);
    for (int i = 0; i < 4; i++) begin
      r      = 24'($urandom);
      awb_en = 1'($urandom);
      drive(1'b0, 1'($urandom), 1'b0, r, r);
    end
    awb_en = 1'b1;
    blank(5);

    // Frames 1 and 2: gray-world stimulus, unity gain while stats build up
    frame_edge("e1", 256, 256);
    pixels(16, 24'h408020, 24'h408020);
    blank(100);
    frame_edge("e2", 256, 256);
    pixels(16, 24'h408020, 24'h408020);
    blank(100);

    // Frame 3: gains from frame 1 (512 / 1024 saturated), plus a clipping R
    frame_edge("e3", 512, 1023);
    pixels(15, 24'h408020, 24'h808080);
    pixels(1, 24'hC88020, 24'hFF8080);
    blank(100);

    // Frame 4: all R = 0, G = 100, B = 50
    frame_edge("e4", 512, 1023);
    pixels(16, 24'h006432, 24'h0064C8);
    blank(100);

    // Frame 5: gains from frame 3 (R sum 1160 -> 451); bypass pixels with hs toggling
    frame_edge("e5", 451, 1023);
    pixels(16, 24'h64C832, 24'hB0C8C8);
    awb_en = 1'b0;
    pixels(4, 24'h804020, 24'h804020);
    awb_en = 1'b1;
    blank(100);

    // Frame 6: zero R divisor from frame 4; second edge 20 cycles later
    frame_edge("e6", 256, 512);
    pixels(8, 24'h326464, 24'h3264C8);
    blank(11);
    frame_edge("e7_abort", 256, 512);
    pixels(16, 24'h408020, 24'h408040);
    blank(100);

    // Gains come from the short frame 6 snapshot
    frame_edge("e8", 512, 256);
    pixels(16, 24'h408020, 24'h808020);
    blank(100);

    // Reset while the B division is in progress
    frame_edge("e9", 512, 1023);
    pixels(16, 24'h408020, 24'h808080);
    blank(33);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    rst = 1'b0;
    check("mid_rst_gain_r", {22'h0, o_gain_r}, 32'd256);
    check("mid_rst_gain_b", {22'h0, o_gain_b}, 32'd256);
    blank(100);
    frame_edge("e10", 256, 256);
    blank(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/awb_gain_apply.md
# awb_gain_apply

Gray-world auto-white-balance stage. Gathers per-frame R/G/B sums from the incoming video stream and derives R and B gains relative to G with a sequential divider during vertical blanking. It applies the gains to the following frame through a fixed 3-cycle pipeline. It sits directly downstream of the sync/RGB delay-alignment stage and presents the same vs/hs/de/rgb stream format on its outputs.

## Interface
- ACC_W, 32: per-channel accumulator width. Covers 1920×1080×255.
- GAIN_W, 10: gain width, unsigned Q2.8.
- GAIN_FRAC, 8: fractional bits of the gain. 1.0 = 256.
- I_clk  in  1  pixel clock, the only clock.
- I_rst  in  1  reset, synchronous, active-high.
- I_awb_en  in  1  1 = apply computed gains; 0 = unity gain, with latency unchanged.
- I_vs  in  1  vertical sync, active high. Rising edge = frame boundary.
- I_hs  in  1  horizontal sync, passed through.
- I_de  in  1  data enable. Pixel is valid when high.
- I_rgb  in  24  pixel: [23:16] R, [15:8] G, [7:0] B.
- O_vs, O_hs, O_de  out  1 each  inputs delayed exactly 3 cycles.
- O_rgb  out  24  gain-corrected pixel, aligned with O_de.
- O_gain_r, O_gain_b  out  GAIN_W  gains currently applied (active registers).

## Operation
- **Statistics.** On every cycle with I_de=1, add R, G and B into acc_r, acc_g and acc_b. The accumulators wrap at ACC_W bits; they must be sized so this never happens.
- **Frame edge.** A rising edge of I_vs is detected by comparing I_vs with its value registered one cycle earlier. On that cycle:
  - copy acc_* into snap_*;
  - clear acc_*. A pixel with I_de=1 on this cycle is dropped from statistics.
  - copy shadow gains into active gains;
  - start the FSM.
- **FSM states:** IDLE → DIV_R → DIV_B → UPDATE → IDLE.
  - DIV_R computes q = (snap_g << GAIN_FRAC) / snap_r with a restoring divider, one quotient bit per cycle over ACC_W+GAIN_FRAC cycles.
  - DIV_B computes the same with snap_b as divisor.
  - If the divisor is 0, the result is 256 and the state advances on the next cycle.
  - If q exceeds 2^GAIN_W−1, the result saturates to 1023.
  - UPDATE writes shadow_r and shadow_b, then returns to IDLE.
- **Frame edge while busy.** If a vs rising edge arrives in DIV_R, DIV_B or UPDATE, abort the current division without writing the shadows. Then take a new snapshot and restart at DIV_R. Active gains still load from the existing shadows.
- **Green gain** is fixed at 256.
- **Gain timing.** Gains therefore take effect one frame after the frame they were measured on. Active gains never change except on a vs rising edge, so no frame ever sees mixed gains.
- **Apply pipeline, per channel:**
  - S1: p = pix × g, 18 bits unsigned. g is the active gain, or 256 when I_awb_en=0.
  - S2: r = (p + 128) >> 8.
  - S3: O = min(r, 255).
- **Sync pipeline.** vs/hs/de pass through a matching 3-stage shift. The pixel pipeline runs every cycle regardless of I_de, so O_rgb is not gated.
- **Unity gain is exact:** (x·256 + 128) >> 8 = x.

## Timing
- Latency from I_* to O_* is exactly 3 cycles for every field. Throughput is 1 pixel/clock with no stalls.
- Divider run: at most 2·(ACC_W+GAIN_FRAC)+1 = 81 cycles from the vs edge to shadow update. This must complete within vertical blanking; the abort rule covers the case where it does not.
- Reset values:
  - all O_* = 0;
  - O_gain_r = O_gain_b = 256;
  - shadows = 256;
  - acc_*, snap_* = 0;
  - FSM = IDLE;
  - the pipeline and the previous-vs register = 0.
- Reset asserted mid-frame or mid-division: all state returns to reset values on the next clock. The pipeline output is zeros for 3 cycles after release.
- The first frame after reset is processed at unity gain. The second frame uses unity gain unless the divider has finished, which it has once blanking is ≥81 cycles.

## Structure
- Shared package awb_pkg contains:
  - GAIN_ONE = 256;
  - GAIN_W, GAIN_FRAC and GAIN_MAX = 1023;
  - the FSM state enum {IDLE, DIV_R, DIV_B, UPDATE};
  - the RGB field slice constants.
- One sub-module, awb_div: a sequential restoring divider.
  - Inputs: start, abort, dividend, divisor.
  - Outputs: done, and a saturated GAIN_W quotient. It handles the zero-divisor case internally.
  - The top level instances it once and reuses it for R, then for B.

## Test plan
- **Reset:** hold I_rst 2 cycles with random inputs → all O_* = 0, O_gain_r = O_gain_b = 256; 3 cycles after release, the outputs track the inputs.
- **Bypass latency:** I_awb_en=0, pixel 0x804020 with de=1 and hs toggling → O_rgb = 0x804020, with O_de and O_hs matching the inputs exactly 3 cycles later.
- **Gray world:**
  - Stimulus: frame 1 of 16 pixels at (R,G,B) = (64,128,32), then ≥100 blanking cycles, then a vs edge, then frame 2 with the same pixels.
  - After frame 2's vs edge: O_gain_r = 512, O_gain_b = 1023 (1024 saturates).
  - Frame 3 pixels output as (128,128,128).
- **Clip:** active gain_r = 512 with R = 200 → O_rgb[23:16] = 255.
- **Zero divisor:** a frame with all R = 0 and G = 100 → gain_r = 256 on the following frame.
- **Abort:**
  - A second vs edge 20 cycles after the first → the divider restarts, the shadows are unchanged by the aborted run, and the final gains match the second snapshot.
  - I_rst asserted during DIV_B → gains return to 256.
